// File: rtl/alu_exec_pkg.sv
// Shared opcode values and FSM state encoding for the sequential ALU executor.
package alu_exec_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_MOVB = 4'd7;
   localparam logic [3:0] OP_EXCH = 4'd8;
   localparam logic [3:0] OP_LDA  = 4'd9;
   localparam logic [3:0] OP_LDB  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Opcodes above LDB are reserved and flagged as errors.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_LDB);
   endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle operation datapath: computes the next A/B and flags for every
// opcode except the serial shift, which the top-level sequences itself.
module alu_exec_comb
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] nextA,
   output logic [WIDTH-1:0] nextB,
   output logic             carry,
   output logic             illegal
);

   // One extra bit holds the ADD carry-out / SUB borrow.
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, A} + {1'b0, B};
   assign w_diff = {1'b0, A} - {1'b0, B};

   // Operation select; NOP, SHR and illegal opcodes leave A and B untouched.
   always_comb begin
      nextA   = A;
      nextB   = B;
      carry   = 1'b0;
      illegal = !is_legal_op(op);
      case (op)
         OP_ADD: begin
            nextA = w_sum[WIDTH-1:0];
            carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            nextA = w_diff[WIDTH-1:0];
            carry = w_diff[WIDTH];
         end
         OP_OR:   nextA = A | B;
         OP_AND:  nextA = A & B;
         OP_XOR:  nextA = A ^ B;
         OP_MOVB: nextA = B;
         OP_EXCH: begin
            nextA = B;
            nextB = A;
         end
         OP_LDA:  nextA = ld_data;
         OP_LDB:  nextB = ld_data;
         default: nextA = A;
      endcase
   end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU executor: operand registers A/B, one opcode per accepted
// command, valid/ready on both sides, and a multi-cycle serial right shift.
module alu_exec_seq
   import alu_exec_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   ld_data,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   outA,
   output logic [WIDTH-1:0]   outB,
   output logic               carry,
   output logic               zero,
   output logic               err
);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_carry;
   logic               r_err;

   logic [WIDTH-1:0]   w_next_a;
   logic [WIDTH-1:0]   w_next_b;
   logic               w_carry;
   logic               w_illegal;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_acc;
   logic               w_shr_start;

   alu_exec_comb #(.WIDTH(WIDTH)) u_comb (
      .op      (op),
      .A       (r_a),
      .B       (r_b),
      .ld_data (ld_data),
      .nextA   (w_next_a),
      .nextB   (w_next_b),
      .carry   (w_carry),
      .illegal (w_illegal)
   );

   // A zero shift amount is an ordinary single-cycle op that leaves A alone.
   assign w_shr_start = (op == OP_SHR) && (shamt != '0);
   assign w_acc       = in_valid && w_in_ready;

   // Next-state and handshake decode; taking a result and accepting a new
   // command on the same edge avoids a bubble between back-to-back ops.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_next_state = w_shr_start ? ST_SHIFT : ST_RESP;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == SHAMT_W'(1)) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            w_out_valid = 1'b1;
            w_in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_next_state = w_shr_start ? ST_SHIFT : ST_RESP;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register; reset abandons any shift in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Operand, counter and flag registers. A shift command only loads the
   // counter at accept; the shifts themselves happen one per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_acc) begin
         if (w_shr_start) begin
            r_cnt   <= shamt;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
         end else begin
            r_a     <= w_next_a;
            r_b     <= w_next_b;
            r_carry <= w_carry;
            r_err   <= w_illegal;
         end
      end else if (r_state == ST_SHIFT) begin
         r_a   <= r_a >> 1;
         r_cnt <= r_cnt - SHAMT_W'(1);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign outA      = r_a;
   assign outB      = r_b;
   assign carry     = r_carry;
   assign zero      = (r_a == '0);
   assign err       = r_err;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed scenarios plus a randomized
// stream scored against a behavioural model of the register file.
module tb_alu_exec_seq;

   localparam int W  = 16;
   localparam int SW = $clog2(W);

   localparam logic [3:0] C_NOP = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2, C_OR = 4'd3;
   localparam logic [3:0] C_XOR = 4'd5, C_SHR = 4'd6, C_EXCH = 4'd8;
   localparam logic [3:0] C_LDA = 4'd9, C_LDB = 4'd10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    op = 4'd0;
   logic [W-1:0]  ld_data = '0;
   logic [SW-1:0] shamt = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  outA, outB;
   logic          carry, zero, err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         e;
      int           rdy;
   } res_t;

   alu_exec_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .ld_data(ld_data), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .outA(outA), .outB(outB), .carry(carry),
      .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   // Present a command and hold it until accepted; returns 1 time unit after the accept edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] d, input logic [SW-1:0] s);
      int t;
      op = o; ld_data = d; shamt = s; in_valid = 1'b1;
      #1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Take the pending result beat.
   task automatic drain();
      int t;
      out_ready = 1'b1;
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL drain_timeout out_valid=%0b required=1", out_valid);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
      checks++; if ({carry, err, zero} !== 3'b001) begin errors++; $display("FAIL rst_flags got c/e/z=%0b%0b%0b exp=001", carry, err, zero); end
      checks++; if (outA !== '0 || outB !== '0) begin errors++; $display("FAIL rst_regs got A=%h B=%h exp=0/0", outA, outB); end
   endtask

   task automatic test_add_basic();
      issue(C_LDA, 16'h0005, '0); drain();
      issue(C_LDB, 16'h0003, '0); drain();
      issue(C_ADD, '0, '0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid=%0b exp=1", out_valid); end
      checks++; if (outA !== 16'h0008 || outB !== 16'h0003) begin errors++; $display("FAIL add_result got A=%h B=%h exp=0008/0003", outA, outB); end
      checks++; if (carry !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL add_flags got c=%0b z=%0b exp=0/0", carry, zero); end
      drain();
   endtask

   task automatic test_carry_borrow();
      issue(C_LDA, 16'hFFFF, '0); drain();
      issue(C_LDB, 16'h0001, '0); drain();
      issue(C_ADD, '0, '0);
      checks++; if (outA !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL add_wrap got A=%h c=%0b z=%0b exp=0000/1/1", outA, carry, zero); end
      drain();
      issue(C_SUB, '0, '0);
      checks++; if (outA !== 16'hFFFF || carry !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL sub_borrow got A=%h c=%0b z=%0b exp=FFFF/1/0", outA, carry, zero); end
      drain();
   endtask

   task automatic test_shift();
      int busy;
      issue(C_LDA, 16'h8000, '0); drain();
      issue(C_SHR, '0, SW'(15));
      busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         if (in_ready !== 1'b0) begin checks++; errors++; $display("FAIL shr_in_ready cycle=%0d got=%0b exp=0", i, in_ready); end
         busy++;
         @(posedge clk); #1;
      end
      checks++; if (busy != 15) begin errors++; $display("FAIL shr_latency got=%0d exp=15", busy); end
      checks++; if (outA !== 16'h0001 || out_valid !== 1'b1) begin errors++; $display("FAIL shr_result got A=%h v=%0b exp=0001/1", outA, out_valid); end
      drain();
      issue(C_LDA, 16'h8000, '0); drain();
      issue(C_SHR, '0, '0);
      checks++; if (out_valid !== 1'b1 || outA !== 16'h8000) begin errors++; $display("FAIL shr0 got A=%h v=%0b exp=8000/1", outA, out_valid); end
      drain();
   endtask

   task automatic test_back_to_back();
      issue(C_LDA, 16'h1234, '0); drain();
      issue(C_LDB, 16'hABCD, '0); drain();
      issue(C_EXCH, '0, '0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || outA !== 16'hABCD || outB !== 16'h1234) begin
            errors++;
            $display("FAIL exch_hold cycle=%0d got v=%0b r=%0b A=%h B=%h exp=1/0/ABCD/1234", i, out_valid, in_ready, outA, outB);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b1; op = C_XOR;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || outA !== 16'hB9F9 || outB !== 16'h1234) begin errors++; $display("FAIL b2b_xor got v=%0b A=%h B=%h exp=1/B9F9/1234", out_valid, outA, outB); end
      drain();
   endtask

   task automatic test_illegal_and_reset();
      issue(C_LDA, 16'h1111, '0); drain();
      issue(C_LDB, 16'h2222, '0); drain();
      issue(4'd12, 16'hFFFF, '0);
      checks++; if (err !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal_err got e=%0b v=%0b exp=1/1", err, out_valid); end
      checks++; if (outA !== 16'h1111 || outB !== 16'h2222) begin errors++; $display("FAIL illegal_regs got A=%h B=%h exp=1111/2222", outA, outB); end
      drain();
      issue(C_OR, '0, '0);
      checks++; if (err !== 1'b0 || outA !== 16'h3333) begin errors++; $display("FAIL err_clear got e=%0b A=%h exp=0/3333", err, outA); end
      drain();
      issue(C_SHR, '0, SW'(8));
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shr_midway got v=%0b exp=0", out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (outA !== '0 || outB !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_shift_reset got A=%h B=%h v=%0b r=%0b exp=0/0/0/1", outA, outB, out_valid, in_ready);
      end
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discarded_result got v=%0b exp=0", out_valid); end
   endtask

   task automatic test_random(input int n);
      logic [W-1:0] ma, mb;
      res_t q[$];
      res_t r;
      int cyc;
      logic exp_ov, exp_ir;
      longint s;
      do_reset();
      ma = '0; mb = '0; cyc = 0;
      for (int c = 0; c < n + 60; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
         op        = 4'($urandom_range(0, 15));
         ld_data   = W'($urandom);
         shamt     = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, W - 1)) : SW'($urandom_range(0, 3));
         #1;
         exp_ov = (q.size() > 0) && (cyc >= q[0].rdy);
         exp_ir = (q.size() == 0) || (exp_ov && out_ready);
         checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ov); end
         checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ir); end
         if (exp_ov && out_ready) begin
            r = q.pop_front();
            checks++;
            if (outA !== r.a || outB !== r.b || carry !== r.c || err !== r.e || zero !== (r.a == '0)) begin
               errors++;
               $display("FAIL rnd_result cyc=%0d got A=%h B=%h c=%0b e=%0b z=%0b exp A=%h B=%h c=%0b e=%0b",
                        cyc, outA, outB, carry, err, zero, r.a, r.b, r.c, r.e);
            end
         end
         if (in_valid && exp_ir) begin
            r.c = 1'b0; r.e = 1'b0; r.rdy = cyc + 1;
            case (op)
               4'd0: ;
               4'd1: begin
                  s = longint'(ma) + longint'(mb);
                  r.c = (s >= (longint'(1) << W));
                  ma = W'(s);
               end
               4'd2: begin r.c = (ma < mb); ma = ma - mb; end
               4'd3: ma = ma | mb;
               4'd4: ma = ma & mb;
               4'd5: ma = ma ^ mb;
               4'd6: begin ma = ma >> shamt; r.rdy = cyc + 1 + int'(shamt); end
               4'd7: ma = mb;
               4'd8: begin r.a = ma; ma = mb; mb = r.a; end
               4'd9: ma = ld_data;
               4'd10: mb = ld_data;
               default: r.e = 1'b1;
            endcase
            r.a = ma; r.b = mb;
            q.push_back(r);
         end
         @(posedge clk); cyc++; #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost_beats pending=%0d exp=0", q.size()); end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_add_basic();
      test_carry_borrow();
      test_shift();
      test_back_to_back();
      test_illegal_and_reset();
      test_random(400);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
